instr_image_loader: RTL and testbench
=====================================

Name: instr_image_loader

Overview:
- Upstream feeder for the top-level core wrapper.
- Accepts a serial stream of 32-bit instruction words plus a start PC.
- Packs the words into main-memory blocks with byte masks and writes each block to main memory over a valid/ready port.
- Once all blocks are written, issues a one-cycle init pulse carrying the start PC to the core.
- Replaces bench-side array initialisation with a cycle-accurate load path.

Parameters:
ADDR_WIDTH, 32, byte address width.
BLOCK_OFFSET_WIDTH, 4, log2 bytes per main-memory block (16 B = 4 words).
INSTR_WIDTH, 32, instruction word width; fixed at 32.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_aH  in  1  synchronous active-high reset.
start  in  1  begin load; sampled only in IDLE or DONE.
start_pc  in  ADDR_WIDTH  address of first word; becomes init PC.
instr_valid  in  1  stream word valid.
instr_ready  out  1  loader accepts word this cycle.
instr_data  in  32  instruction word.
instr_last  in  1  marks final word of image.
mem_wr_valid  out  1  block write request valid.
mem_wr_ready  in  1  memory accepts request.
mem_wr_block_addr  out  ADDR_WIDTH-BLOCK_OFFSET_WIDTH  block address.
mem_wr_block_data  out  8*2^BLOCK_OFFSET_WIDTH  packed block data.
mem_wr_byte_mask  out  2^BLOCK_OFFSET_WIDTH  bytes to write.
core_init  out  1  one-cycle init pulse to core.
core_init_pc  out  ADDR_WIDTH  PC presented with core_init.
busy  out  1  high in FILL, WRITE, or INIT.
done  out  1  high in DONE.
err  out  1  sticky misaligned start_pc flag.

Behaviour:
- **States:** IDLE, FILL, WRITE, INIT, DONE.
- **Reset:** when rst_aH=1 at a clock edge, the loader enters IDLE. All outputs go to 0, the buffer data and mask clear, pc_reg and init_pc_reg clear. This applies in any state; a pending write is dropped even if mem_wr_valid was high.
- **IDLE/DONE + start=1:**
  - If start_pc[1:0]!=0: set err=1 and stay in (or return to) IDLE.
  - Otherwise: clear err, set pc_reg=init_pc_reg=start_pc, clear buffer, go to FILL.
  - start is ignored in FILL, WRITE and INIT.
- **FILL:**
  - instr_ready=1 in FILL only.
  - On an instr_valid&&instr_ready handshake:
    - word index w = pc_reg[BLOCK_OFFSET_WIDTH-1:2];
    - data[32w+:32] = instr_data; mask[4w+:4] = 4'hF;
    - record block addr = pc_reg[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
    - pc_reg += 4, modulo 2^ADDR_WIDTH (wraps to 0).
  - Go to WRITE if w is the last word of the block, or if instr_last=1. Latch last_seen=instr_last.
  - With no handshake, the state holds.
- **WRITE:**
  - mem_wr_valid=1. Address, data and mask are held stable until mem_wr_ready=1.
  - instr_ready=0 (one-block bubble).
  - On handshake: clear buffer and mask. Go to INIT if last_seen, else to FILL.
  - mem_wr_valid drops in the cycle after the handshake.
- **INIT:** core_init=1 and core_init_pc=init_pc_reg for exactly one cycle, then go to DONE.
- **DONE:** done=1 until start or reset. core_init_pc holds its value; core_init=0.
- **Partial blocks:**
  - A first block beginning mid-block has mask bits set only for the words loaded.
  - A last block ending mid-block has mask bits set only for the words loaded.
  - Unloaded bytes in a partial block read as 0 in mem_wr_block_data.
- **Latency:** a full block takes 2^(BLOCK_OFFSET_WIDTH-2) FILL cycles plus at least 1 WRITE cycle. After the final write handshake, core_init is asserted in the next cycle.
- **Wrap-around:** a word at 0xFFFFFFFC followed by another goes to block addr 0 in a new block.

Test Plan:
1. Fibonacci image, 13 words, start_pc=0x1018C, ready always 1. Required response:
   - 4 writes: blk 0x1018 mask 0xF000, then blks 0x1019, 0x101A, 0x101B with mask 0xFFFF.
   - First write's data[127:96]=0x00050613.
   - core_init pulses one cycle later with core_init_pc=0x1018C, then done=1.
2. start_pc=0x1018E → err=1, no write issued, stays IDLE; then start_pc=0x1000 → err clears and a normal load follows.
3. 2 words at 0x1004, instr_last on the 2nd, mem_wr_ready held low 5 cycles → mem_wr_valid stays high and data/mask/addr stay stable; single write blk 0x100 mask 0x0FF0; instr_ready=0 throughout WRITE.
4. rst_aH asserted during WRITE with the request pending → next cycle all outputs are 0, state is IDLE, core_init is never pulsed.
5. start_pc=0xFFFFFFFC, 2 words → write 1 to blk 0x0FFFFFFF mask 0xF000; write 2 to blk 0x0 mask 0x000F.
6. instr_valid toggled 1-0-1-0 → words land at consecutive offsets and the mask accumulates correctly; in DONE, start=1 begins a new load.

Source files
------------

// File: rtl/instr_image_loader_if.sv
// Instruction-stream input and block-write output of the image loader.
// master: loader side (consumes the stream, drives block writes).
// slave: environment side (feeds the stream, accepts block writes).
interface instr_image_loader_if #(
  parameter int ADDR_WIDTH         = 32,
  parameter int BLOCK_OFFSET_WIDTH = 4
);
  localparam int BLK_BYTES = 1 << BLOCK_OFFSET_WIDTH;

  // instruction stream
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic        instr_last;

  // main-memory block write
  logic                                     mem_wr_valid;
  logic                                     mem_wr_ready;
  logic [ADDR_WIDTH-BLOCK_OFFSET_WIDTH-1:0] mem_wr_block_addr;
  logic [8*BLK_BYTES-1:0]                   mem_wr_block_data;
  logic [BLK_BYTES-1:0]                     mem_wr_byte_mask;

  modport master (
    input  instr_valid, instr_data, instr_last, mem_wr_ready,
    output instr_ready, mem_wr_valid, mem_wr_block_addr, mem_wr_block_data, mem_wr_byte_mask
  );

  modport slave (
    output instr_valid, instr_data, instr_last, mem_wr_ready,
    input  instr_ready, mem_wr_valid, mem_wr_block_addr, mem_wr_block_data, mem_wr_byte_mask
  );
endinterface

// File: rtl/instr_image_loader.sv
// Packs a 32-bit instruction stream into masked memory blocks, then pulses core init with the start PC.
// Latency: one FILL cycle per word, >=1 WRITE cycle per block, core_init the cycle after the last write.
// Backpressure: instr_ready only in FILL (one-block bubble while writing); write held until mem_wr_ready.
module instr_image_loader #(
  parameter int ADDR_WIDTH         = 32,
  parameter int BLOCK_OFFSET_WIDTH = 4,
  parameter int INSTR_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst_aH,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_pc,
  instr_image_loader_if.master  bus,
  output logic                  core_init,
  output logic [ADDR_WIDTH-1:0] core_init_pc,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BLK_BYTES  = 1 << BLOCK_OFFSET_WIDTH;
  localparam int WORDS      = BLK_BYTES / 4;
  localparam int WIDX_W     = BLOCK_OFFSET_WIDTH - 2;
  localparam int BLK_AW     = ADDR_WIDTH - BLOCK_OFFSET_WIDTH;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, INIT, DONE} state_t;

  state_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic [ADDR_WIDTH-1:0]  init_pc_reg;
  logic [BLK_AW-1:0]      blk_addr;
  logic [8*BLK_BYTES-1:0] buf_data;
  logic [BLK_BYTES-1:0]   buf_mask;
  logic                   last_seen;
  logic                   err_reg;

  logic [WIDX_W-1:0]      widx;
  logic                   in_hs;
  logic                   start_ok;

  assign widx     = pc_reg[BLOCK_OFFSET_WIDTH-1:2];
  assign in_hs    = (state == FILL) && bus.instr_valid;
  assign start_ok = (start_pc[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst_aH) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state and decoded outputs
  always_comb begin
    state_n                = state;
    bus.instr_ready        = 1'b0;
    bus.mem_wr_valid       = 1'b0;
    core_init              = 1'b0;
    busy                   = 1'b0;
    done                   = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) state_n = start_ok ? FILL : IDLE;
      end
      FILL: begin
        busy            = 1'b1;
        bus.instr_ready = 1'b1;
        if (bus.instr_valid && ((&widx) || bus.instr_last)) state_n = WRITE;
      end
      WRITE: begin
        busy             = 1'b1;
        bus.mem_wr_valid = 1'b1;
        if (bus.mem_wr_ready) state_n = last_seen ? INIT : FILL;
      end
      INIT: begin
        busy      = 1'b1;
        core_init = 1'b1;
        state_n   = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: PC tracking, block buffer packing, error flag
  always_ff @(posedge clk) begin
    if (rst_aH) begin
      pc_reg      <= '0;
      init_pc_reg <= '0;
      blk_addr    <= '0;
      buf_data    <= '0;
      buf_mask    <= '0;
      last_seen   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (!start_ok) begin
              err_reg <= 1'b1;
            end else begin
              err_reg     <= 1'b0;
              pc_reg      <= start_pc;
              init_pc_reg <= start_pc;
              buf_data    <= '0;
              buf_mask    <= '0;
              last_seen   <= 1'b0;
            end
          end
        end
        FILL: begin
          if (in_hs) begin
            for (int i = 0; i < WORDS; i++) begin
              if (widx == WIDX_W'(i)) begin
                buf_data[i*INSTR_WIDTH +: INSTR_WIDTH] <= bus.instr_data;
                buf_mask[i*4 +: 4]                     <= 4'hF;
              end
            end
            blk_addr  <= pc_reg[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH];
            pc_reg    <= pc_reg + ADDR_WIDTH'(4);
            last_seen <= bus.instr_last;
          end
        end
        WRITE: begin
          if (bus.mem_wr_ready) begin
            buf_data <= '0;
            buf_mask <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_wr_block_addr = blk_addr;
  assign bus.mem_wr_block_data = buf_data;
  assign bus.mem_wr_byte_mask  = buf_mask;
  assign core_init_pc          = init_pc_reg;
  assign err                   = err_reg;

endmodule

// File: tb/tb_instr_image_loader.sv
// Directed bench for instr_image_loader: stimulus pushes expected block writes and
// init PCs into queues; an independent monitor pops and compares on each handshake.
module tb_instr_image_loader;

  logic        clk = 1'b0;
  logic        rst_aH;
  logic        start;
  logic [31:0] start_pc;
  logic        core_init;
  logic [31:0] core_init_pc;
  logic        busy, done, err;

  instr_image_loader_if #(.ADDR_WIDTH(32), .BLOCK_OFFSET_WIDTH(4)) bus ();

  instr_image_loader #(.ADDR_WIDTH(32), .BLOCK_OFFSET_WIDTH(4), .INSTR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_aH       (rst_aH),
    .start        (start),
    .start_pc     (start_pc),
    .bus          (bus),
    .core_init    (core_init),
    .core_init_pc (core_init_pc),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_init[$];
  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  int          last_hs_cyc = -10;

  logic [31:0] fib [13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    wr_t e;
    e.addr = a; e.data = d; e.mask = m;
    exp_wr.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic         stalled = 1'b0;
  logic         prev_init = 1'b0;
  logic [27:0]  hold_addr;
  logic [127:0] hold_data;
  logic [15:0]  hold_mask;

  always @(negedge clk) begin
    if (rst_aH) begin
      stalled   = 1'b0;
      prev_init = 1'b0;
    end else begin
      if (prev_init) begin
        chk("init_one_cycle", 128'(core_init), 128'd0);
        chk("done_after_init", 128'(done), 128'd1);
      end
      if (bus.mem_wr_valid) begin
        chk("rdy_low_in_write", 128'(bus.instr_ready), 128'd0);
        if (stalled) begin
          chk("hold_addr", 128'(bus.mem_wr_block_addr), 128'(hold_addr));
          chk("hold_data", bus.mem_wr_block_data, hold_data);
          chk("hold_mask", 128'(bus.mem_wr_byte_mask), 128'(hold_mask));
        end
        if (bus.mem_wr_ready) begin
          stalled     = 1'b0;
          last_hs_cyc = cyc;
          if (exp_wr.size() == 0) begin
            n_chk++; n_bad++;
            $display("FAIL unexpected_write actual_addr=%h required=none", bus.mem_wr_block_addr);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", 128'(bus.mem_wr_block_addr), 128'(e.addr));
            chk("wr_data", bus.mem_wr_block_data, e.data);
            chk("wr_mask", 128'(bus.mem_wr_byte_mask), 128'(e.mask));
          end
        end else begin
          stalled   = 1'b1;
          hold_addr = bus.mem_wr_block_addr;
          hold_data = bus.mem_wr_block_data;
          hold_mask = bus.mem_wr_byte_mask;
        end
      end else begin
        stalled = 1'b0;
      end
      prev_init = core_init;
      if (core_init) begin
        chk("init_latency", 128'(cyc), 128'(last_hs_cyc + 1));
        if (exp_init.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL unexpected_init actual_pc=%h required=none", core_init_pc);
        end else begin
          chk("init_pc", 128'(core_init_pc), 128'(exp_init.pop_front()));
        end
      end
    end
  end

  // ---------------- stimulus helpers (enter/leave #1 after posedge) ----------------
  task automatic start_load(input logic [31:0] pc);
    start = 1'b1; start_pc = pc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok = 0;
    bus.instr_valid = 1'b1; bus.instr_data = d; bus.instr_last = last;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.instr_ready) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) begin
      n_chk++; n_bad++;
      $display("FAIL send_word_timeout actual=no_ready required=ready");
    end else begin
      @(posedge clk); #1;
    end
    bus.instr_valid = 1'b0; bus.instr_last = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
    chk("done_reached", 128'(ok), 128'd1);
    @(posedge clk); #1;
    chk("wr_queue_drained", 128'(exp_wr.size()), 128'd0);
    chk("init_queue_drained", 128'(exp_init.size()), 128'd0);
  endtask

  task automatic wait_wr_valid();
    bit ok = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.mem_wr_valid) ok = 1;
    end
    chk("wr_valid_seen", 128'(ok), 128'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    fib[0]  = 32'h00050613; fib[1]  = 32'h00100693; fib[2]  = 32'h00000713;
    fib[3]  = 32'h00100793; fib[4]  = 32'h00f70833; fib[5]  = 32'h00078713;
    fib[6]  = 32'h00080793; fib[7]  = 32'hfff60613; fib[8]  = 32'hfe0618e3;
    fib[9]  = 32'h00f02023; fib[10] = 32'h00000513; fib[11] = 32'h00008067;
    fib[12] = 32'h0000006f;

    rst_aH = 1'b1; start = 1'b0; start_pc = '0;
    bus.instr_valid = 1'b0; bus.instr_data = '0; bus.instr_last = 1'b0;
    bus.mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_wr_valid", 128'(bus.mem_wr_valid), 128'd0);
    chk("rst_instr_ready", 128'(bus.instr_ready), 128'd0);
    chk("rst_init_pc", 128'(core_init_pc), 128'd0);
    @(posedge clk); #1;
    rst_aH = 1'b0;

    // 1: 13-word image starting in the last word of block 0x1018
    push_wr(28'h1018, {fib[0], 96'h0}, 16'hF000);
    push_wr(28'h1019, {fib[4], fib[3], fib[2], fib[1]}, 16'hFFFF);
    push_wr(28'h101A, {fib[8], fib[7], fib[6], fib[5]}, 16'hFFFF);
    push_wr(28'h101B, {fib[12], fib[11], fib[10], fib[9]}, 16'hFFFF);
    exp_init.push_back(32'h0001018C);
    start_load(32'h0001018C);
    @(negedge clk);
    chk("t1_busy", 128'(busy), 128'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) send_word(fib[i], i == 12);
    wait_done();
    chk("t1_init_pc_hold", 128'(core_init_pc), 128'h1018C);

    // 2: misaligned start -> err, back to IDLE; then aligned start clears err
    start_load(32'h0001018E);
    @(negedge clk);
    chk("t2_err_set", 128'(err), 128'd1);
    chk("t2_idle_done", 128'(done), 128'd0);
    chk("t2_idle_busy", 128'(busy), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    push_wr(28'h100, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 16'hFFFF);
    exp_init.push_back(32'h00001000);
    start_load(32'h00001000);
    @(negedge clk);
    chk("t2_err_clear", 128'(err), 128'd0);
    @(posedge clk); #1;
    send_word(32'hA1, 1'b0); send_word(32'hA2, 1'b0);
    send_word(32'hA3, 1'b0); send_word(32'hA4, 1'b1);
    wait_done();

    // 3: two-word partial block, write stalled five cycles
    bus.mem_wr_ready = 1'b0;
    push_wr(28'h100, {32'h0, 32'hB2, 32'hB1, 32'h0}, 16'h0FF0);
    exp_init.push_back(32'h00001004);
    start_load(32'h00001004);
    send_word(32'hB1, 1'b0); send_word(32'hB2, 1'b1);
    wait_wr_valid();
    repeat (4) @(posedge clk);
    #1;
    bus.mem_wr_ready = 1'b1;
    wait_done();

    // 4: reset while a write is pending
    bus.mem_wr_ready = 1'b0;
    start_load(32'h00002000);
    send_word(32'hC1, 1'b1);
    wait_wr_valid();
    rst_aH = 1'b1;
    @(posedge clk); #1;
    rst_aH = 1'b0;
    bus.mem_wr_ready = 1'b1;
    @(negedge clk);
    chk("t4_wr_valid", 128'(bus.mem_wr_valid), 128'd0);
    chk("t4_addr", 128'(bus.mem_wr_block_addr), 128'd0);
    chk("t4_data", bus.mem_wr_block_data, 128'd0);
    chk("t4_mask", 128'(bus.mem_wr_byte_mask), 128'd0);
    chk("t4_busy", 128'(busy), 128'd0);
    chk("t4_init", 128'(core_init), 128'd0);
    chk("t4_init_pc", 128'(core_init_pc), 128'd0);
    repeat (5) @(posedge clk);
    #1;

    // 5: address wrap across the top of memory
    push_wr(28'hFFFFFFF, {32'hD1, 96'h0}, 16'hF000);
    push_wr(28'h0, {96'h0, 32'hD2}, 16'h000F);
    exp_init.push_back(32'hFFFFFFFC);
    start_load(32'hFFFFFFFC);
    send_word(32'hD1, 1'b0); send_word(32'hD2, 1'b1);
    wait_done();

    // 6: gapped valid, then restart directly from DONE
    push_wr(28'h300, {32'h0, 32'hE3, 32'hE2, 32'hE1}, 16'h0FFF);
    exp_init.push_back(32'h00003000);
    start_load(32'h00003000);
    send_word(32'hE1, 1'b0);
    @(posedge clk); #1;
    send_word(32'hE2, 1'b0);
    @(posedge clk); #1;
    send_word(32'hE3, 1'b1);
    wait_done();
    push_wr(28'h301, {96'h0, 32'hF1}, 16'h000F);
    exp_init.push_back(32'h00003010);
    start_load(32'h00003010);
    @(negedge clk);
    chk("t6_restart_busy", 128'(busy), 128'd1);
    chk("t6_restart_done", 128'(done), 128'd0);
    @(posedge clk); #1;
    send_word(32'hF1, 1'b1);
    wait_done();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
